// File: rtl/reset_sequencer.sv
// Staged reset-release controller: after lock, releases per-domain resets one at a
// time, each after a programmable delay and gated by that stage's init-done ack.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock_in,
  input  logic [NUM_STAGES-1:0] stage_ack,
  input  logic                  clr_fault,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  seq_done,
  output logic                  seq_fault,
  output logic [2:0]            seq_state
);

  localparam int unsigned IDX_W = (NUM_STAGES  > 1) ? $clog2(NUM_STAGES)  : 1;
  localparam int unsigned DLY_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
  localparam int unsigned TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DELAY - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_DELAY     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_DONE      = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DLY_W-1:0]        dly_q, dly_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
  logic                    seq_done_q, seq_done_d;
  logic                    seq_fault_q, seq_fault_d;
  logic                    ack_cur;
  logic [NUM_STAGES-1:0]   cur_mask;

  // One-hot select of the stage currently being sequenced
  always_comb begin
    cur_mask = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (idx_q == IDX_W'(i)) cur_mask[i] = 1'b1;
    end
    ack_cur = |(stage_ack & cur_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dly_q       <= '0;
      to_q        <= '0;
      stage_rst_q <= '1;
      seq_done_q  <= 1'b0;
      seq_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dly_q       <= dly_d;
      to_q        <= to_d;
      stage_rst_q <= stage_rst_d;
      seq_done_q  <= seq_done_d;
      seq_fault_q <= seq_fault_d;
    end
  end

  // Next-state and registered-output logic; lock loss overrides ack and delay expiry
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dly_d       = dly_q;
    to_d        = to_q;
    stage_rst_d = stage_rst_q;

    case (state_q)
      S_IDLE: begin
        state_d     = S_WAIT_LOCK;
        stage_rst_d = '1;
      end
      S_WAIT_LOCK: begin
        stage_rst_d = '1;
        if (lock_in) begin
          state_d = S_DELAY;
          idx_d   = '0;
          dly_d   = '0;
        end
      end
      S_DELAY: begin
        if (!lock_in) begin
          state_d     = S_WAIT_LOCK;
          stage_rst_d = '1;
          idx_d       = '0;
          dly_d       = '0;
          to_d        = '0;
        end else if (dly_q == DLY_LAST) begin
          state_d     = S_WAIT_ACK;
          stage_rst_d = stage_rst_q & ~cur_mask;
          to_d        = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      S_WAIT_ACK: begin
        if (!lock_in) begin
          state_d     = S_WAIT_LOCK;
          stage_rst_d = '1;
          idx_d       = '0;
          dly_d       = '0;
          to_d        = '0;
        end else if (ack_cur) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DELAY;
            idx_d   = idx_q + IDX_W'(1);
            dly_d   = '0;
          end
        end else if (to_q == TO_LAST) begin
          state_d     = S_FAULT;
          stage_rst_d = '1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_DONE: begin
        stage_rst_d = '0;
        if (!lock_in) begin
          state_d     = S_WAIT_LOCK;
          stage_rst_d = '1;
          idx_d       = '0;
          dly_d       = '0;
          to_d        = '0;
        end
      end
      S_FAULT: begin
        stage_rst_d = '1;
        if (clr_fault) begin
          state_d = S_WAIT_LOCK;
          idx_d   = '0;
          dly_d   = '0;
          to_d    = '0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        stage_rst_d = '1;
      end
    endcase

    seq_done_d  = (state_d == S_DONE);
    seq_fault_d = (state_d == S_FAULT);
  end

  assign stage_rst = stage_rst_q;
  assign seq_done  = seq_done_q;
  assign seq_fault = seq_fault_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: nominal release timing, immediate acks,
// ack timeout and clear, ack at the timeout limit, lock loss, reset mid-sequence.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock_in;
  logic [2:0] stage_ack;
  logic       clr_fault;
  logic [2:0] stage_rst;
  logic       seq_done;
  logic       seq_fault;
  logic [2:0] seq_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  reset_sequencer #(
    .NUM_STAGES (3),
    .STAGE_DELAY(16),
    .ACK_TIMEOUT(1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .lock_in  (lock_in),
    .stage_ack(stage_ack),
    .clr_fault(clr_fault),
    .stage_rst(stage_rst),
    .seq_done (seq_done),
    .seq_fault(seq_fault),
    .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are sampled at the end of this cycle
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  // rst high for cycles 0..4, low from cycle 5
  task automatic apply_reset(input logic [2:0] ack);
    rst       = 1'b1;
    lock_in   = 1'b0;
    stage_ack = ack;
    clr_fault = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
    go_to(5);
    rst = 1'b0;
  endtask

  initial begin
    // Nominal sequence with acks 3 cycles after each release
    apply_reset(3'b000);
    go_to(1);
    check("rst_stage_rst", 32'(stage_rst), 32'h7);
    check("rst_done",      32'(seq_done),  32'h0);
    check("rst_fault",     32'(seq_fault), 32'h0);
    check("rst_state",     32'(seq_state), 32'h0);
    go_to(6);
    check("nom_wait_lock", 32'(seq_state), 32'h1);
    go_to(10); lock_in = 1'b1;
    go_to(11);
    check("nom_delay",     32'(seq_state), 32'h2);
    go_to(26);
    check("nom_pre_s0",    32'(stage_rst), 32'h7);
    go_to(27);
    check("nom_s0",        32'(stage_rst), 32'h6);
    check("nom_wait_ack",  32'(seq_state), 32'h3);
    go_to(30); stage_ack = 3'b001;
    go_to(46);
    check("nom_pre_s1",    32'(stage_rst), 32'h6);
    go_to(47);
    check("nom_s1",        32'(stage_rst), 32'h4);
    go_to(50); stage_ack = 3'b011;
    go_to(67);
    check("nom_s2",        32'(stage_rst), 32'h0);
    go_to(70); stage_ack = 3'b111;
    check("nom_pre_done",  32'(seq_done),  32'h0);
    go_to(71);
    check("nom_done",      32'(seq_done),  32'h1);
    check("nom_done_st",   32'(seq_state), 32'h4);
    go_to(75); lock_in = 1'b0;
    go_to(76);
    check("done_lol_done", 32'(seq_done),  32'h0);
    check("done_lol_rst",  32'(stage_rst), 32'h7);
    check("done_lol_st",   32'(seq_state), 32'h1);

    // Immediate acks held from reset: 17-cycle release spacing
    apply_reset(3'b111);
    go_to(10); lock_in = 1'b1;
    go_to(27);
    check("imm_s0",        32'(stage_rst), 32'h6);
    go_to(43);
    check("imm_pre_s1",    32'(stage_rst), 32'h6);
    go_to(44);
    check("imm_s1",        32'(stage_rst), 32'h4);
    go_to(61);
    check("imm_s2",        32'(stage_rst), 32'h0);
    check("imm_pre_done",  32'(seq_done),  32'h0);
    go_to(62);
    check("imm_done",      32'(seq_done),  32'h1);
    check("imm_fault",     32'(seq_fault), 32'h0);

    // Stage 1 ack never comes: fault 1024 cycles after stage 1 release
    apply_reset(3'b001);
    go_to(10); lock_in = 1'b1;
    go_to(30); clr_fault = 1'b1;
    go_to(31); clr_fault = 1'b0;
    check("to_clr_ignored", 32'(seq_state), 32'h2);
    go_to(44);
    check("to_s1",         32'(stage_rst), 32'h4);
    go_to(1067);
    check("to_pre_fault",  32'(seq_fault), 32'h0);
    check("to_pre_state",  32'(seq_state), 32'h3);
    go_to(1068);
    check("to_fault",      32'(seq_fault), 32'h1);
    check("to_fault_rst",  32'(stage_rst), 32'h7);
    check("to_fault_st",   32'(seq_state), 32'h5);
    go_to(1070);
    check("to_fault_hold", 32'(seq_state), 32'h5);
    clr_fault = 1'b1;
    go_to(1071); clr_fault = 1'b0;
    check("to_clr_fault",  32'(seq_fault), 32'h0);
    check("to_clr_state",  32'(seq_state), 32'h1);
    go_to(1087);
    check("to_re_pre_s0",  32'(stage_rst), 32'h7);
    go_to(1088);
    check("to_re_s0",      32'(stage_rst), 32'h6);

    // Ack at the timeout limit wins; wrong-stage ack ignored before it
    apply_reset(3'b000);
    go_to(10); lock_in = 1'b1;
    go_to(27); stage_ack = 3'b100;
    go_to(1049);
    check("lim_wrong_ack", 32'(seq_state), 32'h3);
    go_to(1050); stage_ack = 3'b101;
    go_to(1051);
    check("lim_state",     32'(seq_state), 32'h2);
    check("lim_fault",     32'(seq_fault), 32'h0);
    go_to(1067);
    check("lim_s1",        32'(stage_rst), 32'h4);

    // Lock lost for one cycle while stage_rst=100
    apply_reset(3'b001);
    go_to(10); lock_in = 1'b1;
    go_to(44);
    check("lol_s1",        32'(stage_rst), 32'h4);
    go_to(50); lock_in = 1'b0;
    go_to(51); lock_in = 1'b1;
    check("lol_rst",       32'(stage_rst), 32'h7);
    check("lol_state",     32'(seq_state), 32'h1);
    go_to(67);
    check("lol_pre_s0",    32'(stage_rst), 32'h7);
    go_to(68);
    check("lol_re_s0",     32'(stage_rst), 32'h6);

    // Reset asserted while waiting on stage 2
    apply_reset(3'b011);
    go_to(10); lock_in = 1'b1;
    go_to(61);
    check("mid_s2",        32'(stage_rst), 32'h0);
    go_to(65); rst = 1'b1;
    go_to(66); rst = 1'b0;
    check("mid_rst",       32'(stage_rst), 32'h7);
    check("mid_state",     32'(seq_state), 32'h0);
    check("mid_done",      32'(seq_done),  32'h0);
    go_to(67);
    check("mid_wait_lock", 32'(seq_state), 32'h1);
    go_to(84);
    check("mid_re_s0",     32'(stage_rst), 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
